bcd_to_bin_seq: RTL and testbench



---
 rtl/bcd_to_bin_seq.sv | 124 ++++++++++++
 tb/tb_bcd_to_bin_seq.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq: iterative BCD-to-binary converter (reverse double dabble, one bit per clock)
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : input handshake, bcd_in = packed digits (digit 0 = ones)
//   out_valid/out_ready : output handshake, bin_out = binary value
//   over_limit          : bin_out > LIMIT, bcd_err : some input digit > 9 (both valid with out_valid)
module bcd_to_bin_seq #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10,
    parameter int LIMIT  = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4*DIGITS-1:0] bcd_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BIN_W-1:0]    bin_out,
    output logic                over_limit,
    output logic                bcd_err
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(BIN_W + 1);
    localparam logic [BIN_W-1:0] LIM = BIN_W'(LIMIT);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state_q, state_d;
    logic [BW-1:0] bcd_q, bcd_d, bcd_sh;
    logic [BIN_W-1:0] bin_q, bin_d, bin_sh, bin_out_q, bin_out_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic in_ready_q, in_ready_d, out_valid_q, out_valid_d;
    logic over_limit_q, over_limit_d, bcd_err_q, bcd_err_d;
    logic digit_err;
    // One reverse-double-dabble step: shift the {digits, binary} pair right,
    // then fix up every digit that received a carried-in half-ten (>= 8).
    always_comb begin
        digit_err = 1'b0;
        for (int i = 0; i < DIGITS; i++)
            digit_err = digit_err | (bcd_in[4*i +: 4] > 4'd9);
        bin_sh = {bcd_q[0], bin_q[BIN_W-1:1]};
        bcd_sh = bcd_q >> 1;
        for (int i = 0; i < DIGITS; i++)
            bcd_sh[4*i +: 4] = (bcd_sh[4*i +: 4] >= 4'd8) ? bcd_sh[4*i +: 4] - 4'd3 : bcd_sh[4*i +: 4];
    end
    always_comb begin
        state_d      = state_q;
        bcd_d        = bcd_q;
        bin_d        = bin_q;
        cnt_d        = cnt_q;
        in_ready_d   = in_ready_q;
        out_valid_d  = out_valid_q;
        bin_out_d    = bin_out_q;
        over_limit_d = over_limit_q;
        bcd_err_d    = bcd_err_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    in_ready_d = 1'b0;
                    if (digit_err) begin
                        // Bad digits skip the iterations; out_valid follows one cycle later from DONE.
                        state_d      = DONE;
                        bin_out_d    = '0;
                        over_limit_d = 1'b0;
                        bcd_err_d    = 1'b1;
                    end else begin
                        state_d = SHIFT;
                        bcd_d   = bcd_in;
                        bin_d   = '0;
                        cnt_d   = '0;
                    end
                end
            end
            SHIFT: begin
                bcd_d = bcd_sh;
                bin_d = bin_sh;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(BIN_W - 1)) begin
                    state_d      = DONE;
                    out_valid_d  = 1'b1;
                    bin_out_d    = bin_sh;
                    over_limit_d = bin_sh > LIM;
                    bcd_err_d    = 1'b0;
                end
            end
            DONE: begin
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            bcd_q        <= '0;
            bin_q        <= '0;
            cnt_q        <= '0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            bin_out_q    <= '0;
            over_limit_q <= 1'b0;
            bcd_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            bcd_q        <= bcd_d;
            bin_q        <= bin_d;
            cnt_q        <= cnt_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            bin_out_q    <= bin_out_d;
            over_limit_q <= over_limit_d;
            bcd_err_q    <= bcd_err_d;
        end
    end
    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign bin_out    = bin_out_q;
    assign over_limit = over_limit_q;
    assign bcd_err    = bcd_err_q;
endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// tb_bcd_to_bin_seq: directed and handshake-randomised bench for bcd_to_bin_seq
module tb_bcd_to_bin_seq;
    logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [11:0] bcd_in = '0;
    logic in_ready, out_valid, over_limit, bcd_err;
    logic [9:0] bin_out;
    int checks = 0, errors = 0;

    bcd_to_bin_seq dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .bcd_in(bcd_in),
        .out_valid(out_valid), .out_ready(out_ready), .bin_out(bin_out),
        .over_limit(over_limit), .bcd_err(bcd_err)
    );

    always #5 clk = ~clk;

    task automatic start(input logic [11:0] b);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        in_valid = 1'b1;
        bcd_in = b;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!out_valid && lat < 50);
        if (!out_valid) lat = -1;
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if ({in_ready, out_valid, over_limit, bcd_err, bin_out} !== {4'b1000, 10'd0}) begin
            errors++;
            $display("FAIL reset: got rdy=%b vld=%b ov=%b err=%b bin=%0d want rdy=1 others 0",
                     in_ready, out_valid, over_limit, bcd_err, bin_out);
        end
    endtask

    task automatic test_convert(input logic [11:0] b, input logic [9:0] exp, input logic exp_ov);
        int lat;
        start(b);
        wait_out(lat);
        checks++;
        if (lat !== 10) begin
            errors++;
            $display("FAIL latency %h: got %0d want 10", b, lat);
        end
        checks++;
        if ({bin_out, over_limit, bcd_err} !== {exp, exp_ov, 1'b0}) begin
            errors++;
            $display("FAIL value %h: got bin=%0d ov=%b err=%b want bin=%0d ov=%b err=0",
                     b, bin_out, over_limit, bcd_err, exp, exp_ov);
        end
        checks++;
        if (dut.bcd_q !== 12'h000) begin
            errors++;
            $display("FAIL residue %h: got %h want 000", b, dut.bcd_q);
        end
        take();
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL release %h: got vld=%b rdy=%b want vld=0 rdy=1", b, out_valid, in_ready);
        end
    endtask

    task automatic test_values();
        test_convert(12'h255, 10'd255, 1'b0);
        test_convert(12'h999, 10'd999, 1'b1);
        test_convert(12'h256, 10'd256, 1'b1);
        test_convert(12'h000, 10'd0, 1'b0);
    endtask

    task automatic test_bcd_err();
        int lat;
        start(12'h1A3);
        wait_out(lat);
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("FAIL err_latency: got %0d want 1", lat);
        end
        checks++;
        if ({bin_out, over_limit, bcd_err} !== {10'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL err_value: got bin=%0d ov=%b err=%b want bin=0 ov=0 err=1", bin_out, over_limit, bcd_err);
        end
        take();
    endtask

    task automatic test_stall();
        int lat;
        start(12'h128);
        wait_out(lat);
        checks++;
        if (lat !== 10 || bin_out !== 10'd128 || over_limit !== 1'b0) begin
            errors++;
            $display("FAIL stall_first: got lat=%0d bin=%0d ov=%b want lat=10 bin=128 ov=0", lat, bin_out, over_limit);
        end
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                in_valid = 1'b1;
                bcd_in = 12'h077;
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_ready: got %b want 0", in_ready);
                end
            end
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || bin_out !== 10'd128) begin
                errors++;
                $display("FAIL stall_hold %0d: got vld=%b bin=%0d want vld=1 bin=128", i, out_valid, bin_out);
            end
        end
        take();
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL stall_release: got vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready);
        end
        test_convert(12'h077, 10'd77, 1'b0);
    endtask

    task automatic test_reset_mid();
        start(12'h999);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, over_limit, bcd_err, bin_out} !== {4'b1000, 10'd0} || dut.cnt_q !== '0) begin
            errors++;
            $display("FAIL reset_mid: got rdy=%b vld=%b ov=%b err=%b bin=%0d cnt=%0d want rdy=1 others 0",
                     in_ready, out_valid, over_limit, bcd_err, bin_out, dut.cnt_q);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_convert(12'h042, 10'd42, 1'b0);
    endtask

    task automatic test_back_to_back();
        int q[$];
        int sent = 0, got = 0, cyc = 0, v = 0;
        logic acc;
        while (got < 20 && cyc < 3000) begin
            if (!in_valid && sent < 20) begin
                v = int'($urandom_range(0, 999));
                bcd_in = 12'(((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10));
                in_valid = 1'b1;
            end
            out_ready = 1'($urandom_range(0, 1));
            acc = in_valid && in_ready;
            if (acc) begin
                q.push_back(v);
                sent++;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_extra: got bin=%0d with nothing outstanding", bin_out);
                end else begin
                    if (bin_out !== 10'(q[0]) || over_limit !== (q[0] > 255) || bcd_err !== 1'b0) begin
                        errors++;
                        $display("FAIL b2b_value: got bin=%0d ov=%b err=%b want bin=%0d ov=%b err=0",
                                 bin_out, over_limit, bcd_err, q[0], q[0] > 255);
                    end
                    void'(q.pop_front());
                end
                got++;
            end
            @(posedge clk);
            @(negedge clk);
            if (acc) in_valid = 1'b0;
            cyc++;
        end
        out_ready = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (got !== 20 || sent !== 20 || q.size() !== 0) begin
            errors++;
            $display("FAIL b2b_count: got sent=%0d received=%0d left=%0d want 20/20/0", sent, got, q.size());
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_values();
        test_bcd_err();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
